sign_extend: RTL and testbench

- Immediate-extension unit for the MIPS datapath.
- Takes the 16-bit instruction immediate field (instruction bits 15:0, INSTR_IMM_RANGE) and produces a 32-bit operand for the ALU, branch adder and LUI path.
- Provides a combinational output, used in the same cycle by decode/execute.
- Also provides a registered copy with valid, for the pipelined ID/EX boundary.

---
 rtl/sign_extend_pkg.sv | 24 ++
 rtl/sign_extend_ext_core.sv | 43 ++++
 rtl/sign_extend.sv | 63 ++++++
 tb/tb_sign_extend.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sign_extend_pkg.sv
// -----------------------------------------------------------------------------
// sign_extend_pkg
// Shared definitions for the immediate-extension unit and the decode stage.
//   IMM_W / WORD_W          : immediate field width and datapath word width
//   INSTR_IMM_HI / _LO      : instruction bit range holding the immediate (15:0)
//   EXT_SEXT/ZEXT/LUI/BOFF  : extension mode codes driven on the 2-bit mode bus
// -----------------------------------------------------------------------------
package sign_extend_pkg;

  localparam int IMM_W  = 16;
  localparam int WORD_W = 32;

  // Instruction immediate field, INSTR_IMM_RANGE = [INSTR_IMM_HI:INSTR_IMM_LO]
  localparam int INSTR_IMM_HI = 15;
  localparam int INSTR_IMM_LO = 0;

  localparam int EXT_MODE_W = 2;

  localparam logic [EXT_MODE_W-1:0] EXT_SEXT = 2'd0;  // sign extend
  localparam logic [EXT_MODE_W-1:0] EXT_ZEXT = 2'd1;  // zero extend
  localparam logic [EXT_MODE_W-1:0] EXT_LUI  = 2'd2;  // immediate into upper half
  localparam logic [EXT_MODE_W-1:0] EXT_BOFF = 2'd3;  // sign extend, word -> byte offset

endpackage

// File: rtl/sign_extend_ext_core.sv
// -----------------------------------------------------------------------------
// ext_core
// Purely combinational extension mux. Also instantiated directly by decode.
// Ports:
//   in   [IN_W-1:0]  raw immediate field
//   mode [1:0]       extension mode (EXT_* codes)
//   out  [OUT_W-1:0] extended result, zero latency
// -----------------------------------------------------------------------------
module ext_core
  import sign_extend_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W
) (
  input  logic [IN_W-1:0]       in,
  input  logic [EXT_MODE_W-1:0] mode,
  output logic [OUT_W-1:0]      out
);

  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_lui;
  logic [OUT_W-1:0] w_boff;

  assign w_sext = {{(OUT_W-IN_W){in[IN_W-1]}}, in};
  assign w_zext = {{(OUT_W-IN_W){1'b0}}, in};
  assign w_lui  = {in, {(OUT_W-IN_W){1'b0}}};
  // Branch offsets count words; shifting left by 2 gives bytes and drops
  // the two topmost (redundant) sign bits.
  assign w_boff = {w_sext[OUT_W-3:0], 2'b00};

  always_comb begin
    out = w_sext;
    case (mode)
      EXT_SEXT: out = w_sext;
      EXT_ZEXT: out = w_zext;
      EXT_LUI:  out = w_lui;
      EXT_BOFF: out = w_boff;
      default:  out = w_sext;
    endcase
  end

endmodule

// File: rtl/sign_extend.sv
// -----------------------------------------------------------------------------
// sign_extend
// Immediate-extension unit: combinational result for decode/execute plus a
// registered copy with a valid flag for the ID/EX boundary.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset (clears out_q and valid_q)
//   in      [IN_W-1:0]  raw immediate (instruction bits 15:0)
//   mode    [1:0]       EXT_SEXT / EXT_ZEXT / EXT_LUI / EXT_BOFF
//   en      capture enable for out_q / valid_q
//   out     [OUT_W-1:0] combinational extended result
//   out_q   [OUT_W-1:0] registered extended result
//   valid_q out_q holds a captured value since the last reset
// -----------------------------------------------------------------------------
module sign_extend
  import sign_extend_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       in,
  input  logic [EXT_MODE_W-1:0] mode,
  input  logic                  en,
  output logic [OUT_W-1:0]      out,
  output logic [OUT_W-1:0]      out_q,
  output logic                  valid_q
);

  // BOFF needs two bits of headroom above the immediate.
  if (OUT_W < IN_W + 2) begin : g_bad_width
    $error("sign_extend: OUT_W must be at least IN_W+2");
  end

  logic [OUT_W-1:0] w_ext;
  logic [OUT_W-1:0] r_out_q;
  logic             r_valid_q;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext_core (
    .in   (in),
    .mode (mode),
    .out  (w_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_q   <= '0;
      r_valid_q <= 1'b0;
    end else if (en) begin
      r_out_q   <= w_ext;
      r_valid_q <= 1'b1;
    end
  end

  assign out     = w_ext;
  assign out_q   = r_out_q;
  assign valid_q = r_valid_q;

endmodule

// File: tb/tb_sign_extend.sv
module tb_sign_extend;

  logic        clk;
  logic        rst;
  logic [15:0] tb_in;
  logic [1:0]  tb_mode;
  logic        tb_en;
  logic [31:0] tb_out;
  logic [31:0] tb_out_q;
  logic        tb_valid_q;

  int n_vec;
  int n_miss;

  // expected registered state kept by the bench
  logic [31:0] exp_q[$];
  logic [31:0] m_q;
  logic        m_v;

  sign_extend dut (
    .clk     (clk),
    .rst     (rst),
    .in      (tb_in),
    .mode    (tb_mode),
    .en      (tb_en),
    .out     (tb_out),
    .out_q   (tb_out_q),
    .valid_q (tb_valid_q)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: plain integer arithmetic on the immediate's value
  function automatic logic [31:0] ref_ext(input logic [15:0] v, input logic [1:0] m);
    longint s;
    longint u;
    u = longint'(v);
    s = (u >= 32768) ? u - 65536 : u;
    case (m)
      2'd0:    return 32'(s);
      2'd1:    return 32'(u);
      2'd2:    return 32'(u * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag);
    check({tag, "_out_q"}, tb_out_q, m_q);
    check({tag, "_valid_q"}, {31'd0, tb_valid_q}, {31'd0, m_v});
  endtask

  // apply a combinational vector and check against a required constant
  task automatic comb_vec(input string tag, input logic [15:0] v, input logic [1:0] m,
                          input logic [31:0] exp);
    tb_in   = v;
    tb_mode = m;
    #1;
    check(tag, tb_out, exp);
  endtask

  // one registered cycle: drive at negedge, model the capture, check after posedge
  task automatic reg_cycle(input string tag, input logic [15:0] v, input logic [1:0] m,
                           input logic e);
    @(negedge clk);
    tb_in   = v;
    tb_mode = m;
    tb_en   = e;
    #1;
    check({tag, "_out"}, tb_out, ref_ext(v, m));
    @(posedge clk);
    if (e) begin
      exp_q.push_back(ref_ext(v, m));
      m_q = exp_q.pop_front();
      m_v = 1'b1;
    end
    #1;
    check_reg(tag);
  endtask

  task automatic rst_pulse(input string tag);
    #2;
    rst = 1'b1;
    #1;
    m_q = 32'd0;
    m_v = 1'b0;
    check_reg(tag);
    rst = 1'b0;
  endtask

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    m_q     = 32'd0;
    m_v     = 1'b0;
    rst     = 1'b1;
    tb_en   = 1'b1;
    tb_in   = 16'h1234;
    tb_mode = 2'd0;

    // reset state, including across clock edges with en high
    #1;
    check_reg("reset");
    @(posedge clk);
    #1;
    check_reg("reset_hold_clk");

    @(negedge clk);
    rst   = 1'b0;
    tb_en = 1'b0;

    // directed combinational boundary vectors
    comb_vec("sext_0000", 16'h0000, 2'd0, 32'h0000_0000);
    comb_vec("sext_0001", 16'h0001, 2'd0, 32'h0000_0001);
    comb_vec("sext_ffff", 16'hFFFF, 2'd0, 32'hFFFF_FFFF);
    comb_vec("sext_7fff", 16'h7FFF, 2'd0, 32'h0000_7FFF);
    comb_vec("sext_8000", 16'h8000, 2'd0, 32'hFFFF_8000);
    comb_vec("zext_ffff", 16'hFFFF, 2'd1, 32'h0000_FFFF);
    comb_vec("zext_8000", 16'h8000, 2'd1, 32'h0000_8000);
    comb_vec("lui_8001",  16'h8001, 2'd2, 32'h8001_0000);
    comb_vec("lui_7fff",  16'h7FFF, 2'd2, 32'h7FFF_0000);
    comb_vec("boff_ffff", 16'hFFFF, 2'd3, 32'hFFFF_FFFC);
    comb_vec("boff_0003", 16'h0003, 2'd3, 32'h0000_000C);
    comb_vec("boff_8000", 16'h8000, 2'd3, 32'hFFFE_0000);
    comb_vec("boff_4000", 16'h4000, 2'd3, 32'h0001_0000);
    // en was low throughout: nothing captured yet
    check_reg("no_capture");

    // registered path directed sequence
    reg_cycle("cap_8000", 16'h8000, 2'd0, 1'b1);
    check("cap_8000_const", tb_out_q, 32'hFFFF_8000);
    reg_cycle("hold", 16'h1234, 2'd1, 1'b0);
    check("hold_const", tb_out_q, 32'hFFFF_8000);
    rst_pulse("mid_rst");
    reg_cycle("post_rst_hold", 16'h5555, 2'd2, 1'b0);
    reg_cycle("first_cap", 16'h0003, 2'd3, 1'b1);
    check("first_cap_const", tb_out_q, 32'h0000_000C);

    // randomized cycles against the model
    for (int i = 0; i < 300; i++) begin
      logic [15:0] v;
      logic [1:0]  m;
      logic        e;
      v = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v = 16'h8000 | 16'($urandom_range(0, 3));
        1: v = 16'h7FFF - 16'($urandom_range(0, 3));
        default: ;
      endcase
      m = 2'($urandom_range(0, 3));
      e = ($urandom_range(0, 3) != 0);
      reg_cycle("rand", v, m, e);
      if ($urandom_range(0, 19) == 0) rst_pulse("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
